// File: rtl/elbeth_exs_muldiv.sv
// Iterative RV32M mul/div: 33 stall cycles per normal op, 1 for div-by-zero/overflow, then one DONE cycle.
// Backpressure: ctrl_stall holds the registered result in DONE; ctrl_flush kills any op without a result.
module elbeth_exs_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_flush,
    input  logic             ctrl_stall,
    input  logic             exs_muldiv_en,
    input  logic [2:0]       exs_funct3,
    input  logic [WIDTH-1:0] exs_op_a,
    input  logic [WIDTH-1:0] exs_op_b,
    output logic [WIDTH-1:0] muldiv_result,
    output logic             muldiv_valid,
    output logic             muldiv_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_result;

    logic               w_in_div;
    logic               w_sign_a;
    logic               w_sign_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_spec_res;
    logic               w_accept;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_final;

    // Request decode on the live ID/EX operands
    always_comb begin
        w_in_div   = exs_funct3[2];
        w_sign_a   = w_in_div ? ~exs_funct3[0] : (exs_funct3[1:0] != 2'b11);
        w_sign_b   = w_in_div ? ~exs_funct3[0] : ~exs_funct3[1];
        w_neg_a    = w_sign_a & exs_op_a[WIDTH-1];
        w_neg_b    = w_sign_b & exs_op_b[WIDTH-1];
        w_mag_a    = w_neg_a ? ('0 - exs_op_a) : exs_op_a;
        w_mag_b    = w_neg_b ? ('0 - exs_op_b) : exs_op_b;
        w_div_zero = w_in_div & (exs_op_b == '0);
        w_div_ovf  = w_in_div & ~exs_funct3[0] & (exs_op_a == MIN_NEG) & (exs_op_b == '1);
        w_special  = w_div_zero | w_div_ovf;
        if (w_div_zero) begin
            w_spec_res = exs_funct3[1] ? exs_op_a : '1;
        end else begin
            w_spec_res = exs_funct3[1] ? '0 : MIN_NEG;
        end
        w_accept   = (r_state == S_IDLE) & exs_muldiv_en & ~ctrl_flush;
    end

    // One radix-2 step: shift-add multiply or restoring divide on {r_hi, r_lo}
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        w_diff  = w_shift[WIDTH-1:0] - r_opnd;
        if (r_funct3[2]) begin
            w_hi_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod   = {w_hi_nxt, w_lo_nxt};
        w_prod_s = r_neg_res ? ('0 - w_prod) : w_prod;
        w_quot_s = r_neg_res ? ('0 - w_lo_nxt) : w_lo_nxt;
        w_rem_s  = r_neg_rem ? ('0 - w_hi_nxt) : w_hi_nxt;
        if (r_funct3[2]) begin
            w_final = r_funct3[1] ? w_rem_s : w_quot_s;
        end else begin
            w_final = (r_funct3[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_BUSY;
            S_BUSY: if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
            S_DONE: if (!ctrl_stall) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (ctrl_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt     <= '0;
                r_funct3  <= exs_funct3;
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= w_neg_a;
                // Multiply keeps the multiplicand in r_opnd; divide keeps the divisor
                r_opnd    <= w_in_div ? w_mag_b : w_mag_a;
                r_hi      <= '0;
                r_lo      <= w_in_div ? w_mag_a : w_mag_b;
                if (w_special) r_result <= w_spec_res;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                if (r_cnt == CNT_LAST) r_result <= w_final;
            end
        end
    end

    assign muldiv_result = r_result;
    assign muldiv_valid  = (r_state == S_DONE);
    assign muldiv_stall  = rst & (((r_state == S_IDLE) & exs_muldiv_en & ~ctrl_flush) | (r_state == S_BUSY));

endmodule

// File: tb/tb_elbeth_exs_muldiv.sv
// Directed bench for elbeth_exs_muldiv: latency, results, specials, flush, downstream stall, reset.
module tb_elbeth_exs_muldiv;

    logic        clk;
    logic        rst;
    logic        ctrl_flush;
    logic        ctrl_stall;
    logic        exs_muldiv_en;
    logic [2:0]  exs_funct3;
    logic [31:0] exs_op_a;
    logic [31:0] exs_op_b;
    logic [31:0] muldiv_result;
    logic        muldiv_valid;
    logic        muldiv_stall;

    int n_tests = 0;
    int n_fail  = 0;

    elbeth_exs_muldiv #(.WIDTH(32), .CNT_W(5)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_flush    (ctrl_flush),
        .ctrl_stall    (ctrl_stall),
        .exs_muldiv_en (exs_muldiv_en),
        .exs_funct3    (exs_funct3),
        .exs_op_a      (exs_op_a),
        .exs_op_b      (exs_op_b),
        .muldiv_result (muldiv_result),
        .muldiv_valid  (muldiv_valid),
        .muldiv_stall  (muldiv_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble operands after acceptance, count stall cycles,
    // check the DONE cycle, optionally hold it with ctrl_stall for 'hold' cycles.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall,
                          input int hold);
        int n;
        int nv_busy;
        int nv;
        @(negedge clk);
        exs_muldiv_en = 1'b1;
        exs_funct3    = f3;
        exs_op_a      = a;
        exs_op_b      = b;
        #1;
        n       = 0;
        nv_busy = 0;
        while (muldiv_stall && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            exs_op_a   = ~a;
            exs_op_b   = a ^ b ^ 32'h5a5a_0f0f;
            exs_funct3 = ~f3;
            if (muldiv_stall && muldiv_valid) nv_busy++;
        end
        chk({tag, " stall_cycles"}, n, exp_stall);
        chk({tag, " valid_while_stalled"}, nv_busy, 0);
        chk({tag, " valid"}, {31'd0, muldiv_valid}, 32'd1);
        chk({tag, " result"}, muldiv_result, exp);
        exs_muldiv_en = 1'b0;
        if (hold > 0) begin
            ctrl_stall = 1'b1;
            nv = 1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (i == hold - 1) ctrl_stall = 1'b0;
                if (muldiv_valid && muldiv_result == exp && !muldiv_stall) nv++;
            end
            chk({tag, " held_cycles"}, nv, hold + 1);
        end
        @(posedge clk);
        #1;
        chk({tag, " release"}, {31'd0, muldiv_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b0;
        ctrl_flush    = 1'b0;
        ctrl_stall    = 1'b0;
        exs_muldiv_en = 1'b1;
        exs_funct3    = 3'b000;
        exs_op_a      = 32'd3;
        exs_op_b      = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, muldiv_valid}, 32'd0);
        chk("reset result", muldiv_result, 32'd0);
        chk("reset stall", {31'd0, muldiv_stall}, 32'd0);
        @(negedge clk);
        exs_muldiv_en = 1'b0;
        rst = 1'b1;

        run_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, 0);
        run_op("MUL_min", 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);

        // Reset lands mid-multiply at counter 12
        @(negedge clk);
        exs_muldiv_en = 1'b1;
        exs_funct3    = 3'b000;
        exs_op_a      = 32'd123;
        exs_op_b      = 32'd456;
        @(posedge clk);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst valid", {31'd0, muldiv_valid}, 32'd0);
        chk("midrst result", muldiv_result, 32'd0);
        chk("midrst stall", {31'd0, muldiv_stall}, 32'd0);
        @(negedge clk);
        exs_muldiv_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst stall", {31'd0, muldiv_stall}, 32'd0);
        chk("postrst valid", {31'd0, muldiv_valid}, 32'd0);

        run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("DIVnn",  3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33, 0);
        run_op("REMnn",  3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 0);
        run_op("DIVU",   3'b101, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("REMU",   3'b111, 32'd100, 32'd7, 32'd2, 33, 0);

        run_op("DIVU0",  3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("REMU0",  3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("DIV0",   3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("REM0",   3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
        run_op("DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("REMovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Request together with flush in IDLE is dropped
        @(negedge clk);
        exs_muldiv_en = 1'b1;
        ctrl_flush    = 1'b1;
        exs_funct3    = 3'b101;
        exs_op_a      = 32'd50;
        exs_op_b      = 32'd5;
        #1;
        chk("flushreq stall", {31'd0, muldiv_stall}, 32'd0);
        @(posedge clk);
        #1;
        ctrl_flush    = 1'b0;
        exs_muldiv_en = 1'b0;
        chk("flushreq valid", {31'd0, muldiv_valid}, 32'd0);
        chk("flushreq idle", {31'd0, muldiv_stall}, 32'd0);

        // Flush at BUSY counter 10, then a back-to-back DIVU
        @(negedge clk);
        exs_muldiv_en = 1'b1;
        exs_funct3    = 3'b101;
        exs_op_a      = 32'd1000;
        exs_op_b      = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        ctrl_flush    = 1'b1;
        exs_muldiv_en = 1'b0;
        @(posedge clk);
        #1;
        ctrl_flush = 1'b0;
        chk("flush valid", {31'd0, muldiv_valid}, 32'd0);
        chk("flush stall", {31'd0, muldiv_stall}, 32'd0);
        run_op("DIVU_after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 33, 0);

        run_op("DIVU_held", 3'b101, 32'd100, 32'd7, 32'd14, 33, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elbeth_exs_muldiv.md
Name: elbeth_exs_muldiv

Overview:
Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the registered funct3 and the post-forwarding rs1/rs2 operands. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, and it asserts a stall that freezes the ID/EX register until its result is ready for the EX/MEM register.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported (RV32M).
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  synchronous reset, active-low.
ctrl_flush  input  1  kill in-flight operation (exception/branch redirect).
ctrl_stall  input  1  downstream stall; holds a completed result.
exs_muldiv_en  input  1  current EX instruction is an M-extension op.
exs_funct3  input  3  M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
exs_op_a  input  WIDTH  rs1 operand (post-forwarding).
exs_op_b  input  WIDTH  rs2 operand (post-forwarding).
muldiv_result  output  WIDTH  result; meaningful only while muldiv_valid is high.
muldiv_valid  output  1  result ready this cycle.
muldiv_stall  output  1  freeze PC/IF-ID/ID-EX this cycle.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, counter=0, muldiv_result=0, muldiv_valid=0. muldiv_stall is 0 while held in reset. Reset overrides flush, stall and an in-flight operation.
- FSM states are IDLE, BUSY, DONE.
- IDLE, exs_muldiv_en=1, no flush: latch the operands and funct3, then decide the path:
  - Special case (divide-by-zero or signed overflow): go to DONE (1 stall cycle).
  - Otherwise: go to BUSY with counter=0.
- BUSY: one radix-2 step per cycle, 32 steps (counter 0..31). After the step with counter==31, go to DONE.
- DONE: muldiv_valid=1 and muldiv_result is registered and stable. Stay in DONE while ctrl_stall=1. Otherwise go to IDLE next cycle.
- muldiv_stall = (IDLE & exs_muldiv_en & ~ctrl_flush) | BUSY. It is combinational, so it asserts in the request cycle. It is 0 in DONE, which lets the pipeline advance and prevents re-issue.
- Normal-op latency: 33 stall cycles, then the DONE cycle. Special-case latency: 1 stall cycle, then DONE.
- ctrl_flush=1 in any state: go to IDLE next cycle, muldiv_valid=0. No result is ever presented for the killed op.
- Flush and exs_muldiv_en high in the same IDLE cycle: the request is not accepted.
- Operands are not re-sampled after acceptance; later input changes are ignored until the next IDLE.
- Multiply datapath:
  - Take magnitudes: a is signed for MUL/MULH/MULHSU; b is signed for MUL/MULH.
  - Shift-add into a 64-bit product.
  - Negate the 64-bit product if sign_a^sign_b.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide datapath:
  - Restoring division on magnitudes; operands are signed for DIV/REM.
  - Quotient sign is sign_a^sign_b; remainder sign is sign_a (dividend).
- Special cases:
  - b==0: quotient is all-ones (0xFFFFFFFF) for DIV/DIVU; remainder is a for REM/REMU.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- All arithmetic is modulo 2^WIDTH. Negation is two's-complement. Magnitude of 0x80000000 is 0x80000000 interpreted as unsigned.

Test Plan:
- Reset mid-operation: rst=0 at BUSY counter=12 → next cycle IDLE, valid=0, result=0, stall=0.
- MUL: a=7, b=0xFFFFFFFD, funct3=000 → stall high for 33 cycles, then valid=1 with result=0xFFFFFFEB.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU with the same operands → 2.
- Special cases, each with exactly 1 stall cycle:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Flush and downstream stall:
  - ctrl_flush at BUSY counter=10 → IDLE next cycle, valid never asserts; a back-to-back new DIVU 9/3 then returns 3.
  - ctrl_stall=1 for 4 cycles while in DONE → valid and result held for 5 cycles total, and stall stays 0.
